// File: rtl/pcs_tx_blk_enc.sv
// 10GBASE-R transmit block encoder: packs PHY words from the MAC TX pipe
// into 66-bit blocks (2-bit sync header + 64-bit payload) and classifies
// each block as idle, start, data, terminate or error.
module pcs_tx_blk_enc #(
  parameter int DATA_W      = 16,
  parameter int BLOCK_W     = 64,
  parameter int WORD_N      = BLOCK_W / DATA_W,
  parameter int BLOCK_LEN_W = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   mac_ctrl_v_i,
  input  logic [DATA_W-1:0]      mac_data_i,
  input  logic                   mac_start_i,
  input  logic                   mac_idle_i,
  input  logic                   mac_term_i,
  input  logic [BLOCK_LEN_W-1:0] mac_term_len_i,
  output logic                   mac_ready_o,
  output logic                   mac_lane0_o,
  output logic                   blk_v_o,
  output logic [1:0]             blk_head_o,
  output logic [BLOCK_W-1:0]     blk_data_o,
  input  logic                   blk_ready_i,
  output logic                   err_o,
  output logic [ERR_CNT_W-1:0]   err_cnt_o
);

  localparam int LANE_W = (WORD_N > 1) ? $clog2(WORD_N) : 1;

  typedef enum logic [2:0] {W_IDLE, W_START, W_DATA, W_TERM, W_BAD} wcls_t;
  typedef enum logic {S_IDLE, S_DATA} state_t;

  state_t                 state, state_next;
  logic [LANE_W-1:0]      lane;
  logic                   accept, blk_done;
  wcls_t                  in_cls;
  logic [DATA_W-1:0]      buf_data [WORD_N];
  wcls_t                  buf_cls  [WORD_N];
  wcls_t                  w_cls    [WORD_N];
  logic [BLOCK_LEN_W-1:0] len0_q, len0;
  logic [BLOCK_W-1:0]     payload, term_data;
  logic                   all_idle, all_data, rest_data, rest_ok;
  logic [1:0]             nxt_head;
  logic [BLOCK_W-1:0]     nxt_data;
  logic                   nxt_err;
  logic [7:0]             term_type;

  assign mac_ready_o = ~blk_v_o | blk_ready_i;
  assign mac_lane0_o = (lane == '0);
  assign accept      = mac_ready_o;
  assign blk_done    = accept && (lane == LANE_W'(WORD_N - 1));
  assign len0        = (WORD_N == 1) ? mac_term_len_i : len0_q;

  // Classify the incoming word from its control flags.
  always_comb begin
    in_cls = W_BAD;
    if (mac_start_i && mac_ctrl_v_i)
      in_cls = W_START;
    else if (mac_term_i && mac_ctrl_v_i && mac_term_len_i <= BLOCK_LEN_W'(7))
      in_cls = W_TERM;
    else if (mac_idle_i && !mac_start_i && !mac_term_i)
      in_cls = W_IDLE;
    else if (!mac_ctrl_v_i && !mac_idle_i && !mac_start_i && !mac_term_i)
      in_cls = W_DATA;
  end

  // Lane counter: one step per accepted word, wrapping at the block end.
  always_ff @(posedge clk) begin
    if (!nreset)
      lane <= '0;
    else if (accept)
      lane <= (lane == LANE_W'(WORD_N - 1)) ? '0 : lane + 1'b1;
  end

  // Word buffer for the leading lanes; reset only needs the lane counter.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_data[lane] <= mac_data_i;
      buf_cls[lane]  <= in_cls;
      if (lane == '0)
        len0_q <= mac_term_len_i;
    end
  end

  // Assemble the complete block: buffered lanes plus the current last word.
  always_comb begin
    payload = '0;
    for (int unsigned i = 0; i < WORD_N; i++) begin
      if (i == WORD_N - 1) begin
        w_cls[i]                    = in_cls;
        payload[i*DATA_W +: DATA_W] = mac_data_i;
      end else begin
        w_cls[i]                    = buf_cls[i];
        payload[i*DATA_W +: DATA_W] = buf_data[i];
      end
    end
  end

  // Terminate payload: type byte, then the first len0 input bytes.
  always_comb begin
    case (len0)
      BLOCK_LEN_W'(0): term_type = 8'h87;
      BLOCK_LEN_W'(1): term_type = 8'h99;
      BLOCK_LEN_W'(2): term_type = 8'hAA;
      BLOCK_LEN_W'(3): term_type = 8'hB4;
      BLOCK_LEN_W'(4): term_type = 8'hCC;
      BLOCK_LEN_W'(5): term_type = 8'hD2;
      BLOCK_LEN_W'(6): term_type = 8'hE1;
      BLOCK_LEN_W'(7): term_type = 8'hFF;
      default:         term_type = 8'h1E;
    endcase
    term_data      = '0;
    term_data[7:0] = term_type;
    for (int unsigned j = 1; j < BLOCK_W / 8; j++) begin
      if (j <= 32'(len0))
        term_data[j*8 +: 8] = payload[(j-1)*8 +: 8];
    end
  end

  // Frame state register; advances only when a block completes.
  always_ff @(posedge clk) begin
    if (!nreset)
      state <= S_IDLE;
    else if (blk_done)
      state <= state_next;
  end

  // Block classification and next frame state.
  always_comb begin
    all_idle  = 1'b1;
    all_data  = 1'b1;
    rest_data = 1'b1;
    rest_ok   = 1'b1;
    for (int unsigned i = 0; i < WORD_N; i++) begin
      if (w_cls[i] != W_IDLE) all_idle = 1'b0;
      if (w_cls[i] != W_DATA) all_data = 1'b0;
      if (i > 0) begin
        if (w_cls[i] != W_DATA) rest_data = 1'b0;
        if (w_cls[i] == W_START || w_cls[i] == W_BAD) rest_ok = 1'b0;
      end
    end
    state_next = state;
    nxt_head   = 2'b01;
    nxt_data   = {{8{7'h1E}}, 8'h1E};
    nxt_err    = 1'b1;
    case (state)
      S_IDLE: begin
        if (all_idle) begin
          nxt_data = {{(BLOCK_W-8){1'b0}}, 8'h1E};
          nxt_err  = 1'b0;
        end else if (w_cls[0] == W_START && rest_data) begin
          nxt_data   = {payload[BLOCK_W-1:8], 8'h78};
          nxt_err    = 1'b0;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        state_next = S_IDLE;
        if (all_data) begin
          nxt_head   = 2'b10;
          nxt_data   = payload;
          nxt_err    = 1'b0;
          state_next = S_DATA;
        end else if (w_cls[0] == W_TERM && rest_ok) begin
          nxt_data = term_data;
          nxt_err  = 1'b0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output register: load on block completion, hold under backpressure.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      blk_v_o    <= 1'b0;
      blk_head_o <= '0;
      blk_data_o <= '0;
      err_o      <= 1'b0;
      err_cnt_o  <= '0;
    end else if (blk_done) begin
      blk_v_o    <= 1'b1;
      blk_head_o <= nxt_head;
      blk_data_o <= nxt_data;
      err_o      <= nxt_err;
      if (nxt_err && err_cnt_o != '1)
        err_cnt_o <= err_cnt_o + 1'b1;
    end else if (blk_ready_i) begin
      blk_v_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcs_tx_blk_enc.sv
// Directed testbench for pcs_tx_blk_enc with DATA_W=16 (four words per block).
module tb_pcs_tx_blk_enc;

  logic        clk = 1'b0;
  logic        nreset;
  logic        ctrl_v, start, idle, term;
  logic [15:0] data;
  logic [3:0]  term_len;
  logic        mac_ready, mac_lane0, blk_v, blk_ready, err;
  logic [1:0]  blk_head;
  logic [63:0] blk_data;
  logic [7:0]  err_cnt;

  int tests = 0;
  int fails = 0;

  localparam logic [63:0] ERR_BLK  = {{8{7'h1E}}, 8'h1E};
  localparam logic [63:0] IDLE_BLK = 64'h000000000000001E;

  always #5 clk = ~clk;

  pcs_tx_blk_enc #(.DATA_W(16), .BLOCK_W(64), .BLOCK_LEN_W(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .nreset(nreset),
    .mac_ctrl_v_i(ctrl_v), .mac_data_i(data), .mac_start_i(start),
    .mac_idle_i(idle), .mac_term_i(term), .mac_term_len_i(term_len),
    .mac_ready_o(mac_ready), .mac_lane0_o(mac_lane0),
    .blk_v_o(blk_v), .blk_head_o(blk_head), .blk_data_o(blk_data),
    .blk_ready_i(blk_ready), .err_o(err), .err_cnt_o(err_cnt)
  );

  // Present one word and let it be accepted (bounded wait for ready).
  task automatic send_word(input logic cv, input logic [15:0] d, input logic st,
                           input logic id, input logic tm, input logic [3:0] len);
    int n = 0;
    ctrl_v = cv; data = d; start = st; idle = id; term = tm; term_len = len;
    while (!mac_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!mac_ready) begin
      tests++; fails++;
      $display("FAIL ready_timeout got mac_ready=%b exp 1", mac_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic w_idle();                                send_word(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0); endtask
  task automatic w_data(input logic [15:0] d);            send_word(1'b0, d, 1'b0, 1'b0, 1'b0, 4'd0); endtask
  task automatic w_start(input logic [15:0] d);           send_word(1'b1, d, 1'b1, 1'b0, 1'b0, 4'd0); endtask
  task automatic w_term(input logic [15:0] d, input logic [3:0] l); send_word(1'b1, d, 1'b0, 1'b0, 1'b1, l); endtask
  task automatic w_bad();                                 send_word(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0); endtask

  task automatic test_reset();
    nreset = 1'b0; blk_ready = 1'b1;
    ctrl_v = 1'b0; data = '0; start = 1'b0; idle = 1'b1; term = 1'b0; term_len = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (blk_v !== 1'b0)    begin fails++; $display("FAIL rst_v got %b exp 0", blk_v); end
    tests++; if (blk_head !== 2'b00) begin fails++; $display("FAIL rst_head got %b exp 00", blk_head); end
    tests++; if (blk_data !== 64'h0) begin fails++; $display("FAIL rst_data got %h exp 0", blk_data); end
    tests++; if (err !== 1'b0 || err_cnt !== 8'd0) begin fails++; $display("FAIL rst_err got %b/%0d exp 0/0", err, err_cnt); end
    tests++; if (mac_ready !== 1'b1 || mac_lane0 !== 1'b1) begin fails++; $display("FAIL rst_ready_lane0 got %b/%b exp 1/1", mac_ready, mac_lane0); end
    nreset = 1'b1;
  endtask

  task automatic test_idle();
    w_idle(); w_idle(); w_idle();
    tests++; if (blk_v !== 1'b0 || mac_lane0 !== 1'b0) begin fails++; $display("FAIL idle_pending got v=%b lane0=%b exp 0/0", blk_v, mac_lane0); end
    w_idle();
    tests++; if (blk_v !== 1'b1 || blk_head !== 2'b01 || blk_data !== IDLE_BLK || err !== 1'b0)
      begin fails++; $display("FAIL idle_blk got v=%b h=%b d=%h e=%b exp 1/01/%h/0", blk_v, blk_head, blk_data, err, IDLE_BLK); end
    tests++; if (mac_lane0 !== 1'b1) begin fails++; $display("FAIL idle_lane0 got %b exp 1", mac_lane0); end
  endtask

  task automatic test_start();
    w_start(16'h5555); w_data(16'h5555); w_data(16'h5555); w_data(16'hD555);
    tests++; if (blk_v !== 1'b1 || blk_head !== 2'b01 || blk_data !== 64'hD555555555555578 || err !== 1'b0)
      begin fails++; $display("FAIL start_blk got h=%b d=%h e=%b exp 01/d555555555555578/0", blk_head, blk_data, err); end
  endtask

  task automatic test_data();
    w_data(16'h0201); w_data(16'h0403); w_data(16'h0605); w_data(16'h0807);
    tests++; if (blk_head !== 2'b10 || blk_data !== 64'h0807060504030201 || err !== 1'b0)
      begin fails++; $display("FAIL data_blk got h=%b d=%h exp 10/0807060504030201", blk_head, blk_data); end
  endtask

  task automatic test_term();
    w_term(16'hBBAA, 4'd3); w_data(16'h00CC); w_idle(); w_idle();
    tests++; if (blk_head !== 2'b01 || blk_data !== 64'h00000000CCBBAAB4 || err !== 1'b0)
      begin fails++; $display("FAIL term3_blk got h=%b d=%h exp 01/00000000ccbbaab4", blk_head, blk_data); end
    // back in IDLE: an all-idle block must be a clean idle block
    w_idle(); w_idle(); w_idle(); w_idle();
    tests++; if (blk_data !== IDLE_BLK || err !== 1'b0) begin fails++; $display("FAIL term_to_idle got d=%h e=%b exp %h/0", blk_data, err, IDLE_BLK); end
    w_start(16'h5555); w_data(16'h1111); w_data(16'h2222); w_data(16'h3333);
    w_term(16'h9999, 4'd0); w_idle(); w_idle(); w_idle();
    tests++; if (blk_head !== 2'b01 || blk_data !== 64'h0000000000000087 || err !== 1'b0)
      begin fails++; $display("FAIL term0_blk got h=%b d=%h exp 01/0000000000000087", blk_head, blk_data); end
    w_start(16'h5555); w_data(16'h1111); w_data(16'h2222); w_data(16'h3333);
    w_term(16'h2211, 4'd7); w_data(16'h4433); w_data(16'h6655); w_data(16'h8877);
    tests++; if (blk_data !== 64'h77665544332211FF || err !== 1'b0)
      begin fails++; $display("FAIL term7_blk got d=%h exp 77665544332211ff", blk_data); end
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    w_idle();
    blk_ready = 1'b0;
    w_idle(); w_idle(); w_idle();
    held = blk_data;
    tests++; if (blk_v !== 1'b1 || held !== IDLE_BLK || mac_ready !== 1'b0)
      begin fails++; $display("FAIL bp_hold got v=%b d=%h rdy=%b exp 1/%h/0", blk_v, held, mac_ready, IDLE_BLK); end
    ctrl_v = 1'b1; data = 16'hAB00; start = 1'b1; idle = 1'b0; term = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      tests++; if (blk_v !== 1'b1 || blk_data !== IDLE_BLK || mac_ready !== 1'b0 || mac_lane0 !== 1'b1)
        begin fails++; $display("FAIL bp_stall got v=%b d=%h rdy=%b lane0=%b exp 1/%h/0/1", blk_v, blk_data, mac_ready, mac_lane0, IDLE_BLK); end
    end
    blk_ready = 1'b1;
    #1;
    tests++; if (mac_ready !== 1'b1) begin fails++; $display("FAIL bp_release got rdy=%b exp 1", mac_ready); end
    w_start(16'hAB00); w_data(16'h1111); w_data(16'h2222); w_data(16'h3333);
    tests++; if (blk_data !== 64'h333322221111AB78 || err !== 1'b0)
      begin fails++; $display("FAIL bp_after got d=%h exp 333322221111ab78", blk_data); end
    w_term(16'h0000, 4'd0); w_idle(); w_idle(); w_idle();
  endtask

  task automatic test_error();
    w_idle(); w_idle(); w_start(16'h0000); w_idle();
    tests++; if (blk_head !== 2'b01 || blk_data !== ERR_BLK || err !== 1'b1 || err_cnt !== 8'd1)
      begin fails++; $display("FAIL err_lane2_start got h=%b d=%h e=%b c=%0d exp 01/%h/1/1", blk_head, blk_data, err, err_cnt, ERR_BLK); end
    w_idle(); w_idle(); w_idle(); w_idle();
    tests++; if (err !== 1'b0 || err_cnt !== 8'd1 || blk_data !== IDLE_BLK)
      begin fails++; $display("FAIL err_recover got e=%b c=%0d d=%h exp 0/1/%h", err, err_cnt, blk_data, IDLE_BLK); end
    // DATA state receiving idle words is an error and falls back to IDLE
    w_start(16'h0000); w_data(16'h1); w_data(16'h2); w_data(16'h3);
    w_idle(); w_idle(); w_idle(); w_idle();
    tests++; if (err !== 1'b1 || err_cnt !== 8'd2 || blk_data !== ERR_BLK)
      begin fails++; $display("FAIL err_data_state got e=%b c=%0d exp 1/2", err, err_cnt); end
    for (int k = 0; k < 298; k++) begin
      w_bad(); w_bad(); w_bad(); w_bad();
    end
    tests++; if (err_cnt !== 8'd255 || err !== 1'b1) begin fails++; $display("FAIL err_saturate got c=%0d e=%b exp 255/1", err_cnt, err); end
    w_idle(); w_idle(); w_idle(); w_idle();
    tests++; if (err_cnt !== 8'd255 || err !== 1'b0 || blk_data !== IDLE_BLK)
      begin fails++; $display("FAIL err_sat_hold got c=%0d e=%b d=%h exp 255/0/%h", err_cnt, err, blk_data, IDLE_BLK); end
  endtask

  task automatic test_reset_mid();
    w_start(16'h0000); w_data(16'h1); w_data(16'h2); w_data(16'h3);
    w_data(16'h4); w_data(16'h5);
    nreset = 1'b0;
    ctrl_v = 1'b0; data = '0; start = 1'b0; idle = 1'b1; term = 1'b0;
    @(posedge clk); #1;
    tests++; if (blk_v !== 1'b0 || mac_lane0 !== 1'b1 || err_cnt !== 8'd0 || mac_ready !== 1'b1)
      begin fails++; $display("FAIL rst_mid got v=%b lane0=%b c=%0d rdy=%b exp 0/1/0/1", blk_v, mac_lane0, err_cnt, mac_ready); end
    nreset = 1'b1;
    w_idle(); w_idle(); w_idle(); w_idle();
    tests++; if (blk_data !== IDLE_BLK || err !== 1'b0 || blk_head !== 2'b01)
      begin fails++; $display("FAIL rst_mid_idle got h=%b d=%h e=%b exp 01/%h/0", blk_head, blk_data, err, IDLE_BLK); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_start();
    test_data();
    test_term();
    test_backpressure();
    test_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
